// File: rtl/user_wb_pkg.sv
// user_wb_pkg: shared state type and defaults for the user-area Wishbone arbiter
package user_wb_pkg;
    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
    localparam int AW_DEF = 32;
    localparam int DW_DEF = 32;
    localparam int TIMEOUT_DEF = 255;
    localparam logic [31:0] TO_DATA_DEF = 32'hBADC_0DE5;
endpackage

// File: rtl/wb_watchdog.sv
// wb_watchdog: counts strobe cycles without ack and flags a hung transfer
//   clk, rst  : clock, synchronous active-high reset
//   active    : current owner is strobing the slave
//   ack       : slave ack; a real ack always beats the watchdog
//   to_hit    : force termination of the current transfer this cycle
module wb_watchdog
    import user_wb_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic ack,
    output logic to_hit
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);
    logic [CW-1:0] cnt;
    assign to_hit = active & ~ack & (cnt == LIMIT);
    // restart after every ack or forced termination; idle/ownerless cycles hold it at zero
    always_ff @(posedge clk)
        cnt <= (rst | ~active | ack | to_hit) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/user_wb_arbiter.sv
// user_wb_arbiter: round-robin sharing of the user Wishbone slave bus between two masters
//   wb_clk_i, wb_rst_i         : clock, synchronous active-high reset
//   m0_*, m1_*                 : master ports (m0 = management SoC, m1 = in-project master)
//   s_*                        : slave side, driven only by the current owner
//   grant_o                    : one-hot owner, 00 when idle
//   timeout_o, timeout_clr_i   : sticky forced-termination flag and its clear
module user_wb_arbiter
    import user_wb_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter logic [DW-1:0] TO_DATA = TO_DATA_DEF
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic            m0_cyc_i,
    input  logic            m0_stb_i,
    input  logic            m0_we_i,
    input  logic [DW/8-1:0] m0_sel_i,
    input  logic [AW-1:0]   m0_adr_i,
    input  logic [DW-1:0]   m0_dat_i,
    output logic            m0_ack_o,
    output logic [DW-1:0]   m0_dat_o,
    input  logic            m1_cyc_i,
    input  logic            m1_stb_i,
    input  logic            m1_we_i,
    input  logic [DW/8-1:0] m1_sel_i,
    input  logic [AW-1:0]   m1_adr_i,
    input  logic [DW-1:0]   m1_dat_i,
    output logic            m1_ack_o,
    output logic [DW-1:0]   m1_dat_o,
    output logic            s_cyc_o,
    output logic            s_stb_o,
    output logic            s_we_o,
    output logic [DW/8-1:0] s_sel_o,
    output logic [AW-1:0]   s_adr_o,
    output logic [DW-1:0]   s_dat_o,
    input  logic            s_ack_i,
    input  logic [DW-1:0]   s_dat_i,
    output logic [1:0]      grant_o,
    output logic            timeout_o,
    input  logic            timeout_clr_i
);
    state_t st;
    logic last;
    logic own0, own1, req0, req1, active, to_hit;
    assign own0 = st == OWN0;
    assign own1 = st == OWN1;
    assign req0 = m0_cyc_i & m0_stb_i;
    assign req1 = m1_cyc_i & m1_stb_i;
    assign active = own0 ? req0 : own1 & req1;
    assign grant_o = {own1, own0};
    assign s_cyc_o = (own0 & m0_cyc_i) | (own1 & m1_cyc_i);
    assign s_stb_o = active & ~to_hit;
    assign s_we_o = (own0 & m0_we_i) | (own1 & m1_we_i);
    assign s_sel_o = own0 ? m0_sel_i : own1 ? m1_sel_i : '0;
    assign s_adr_o = own0 ? m0_adr_i : own1 ? m1_adr_i : '0;
    assign s_dat_o = own0 ? m0_dat_i : own1 ? m1_dat_i : '0;
    assign m0_ack_o = own0 & (s_ack_i | to_hit);
    assign m1_ack_o = own1 & (s_ack_i | to_hit);
    assign m0_dat_o = own0 ? (to_hit ? TO_DATA : s_dat_i) : '0;
    assign m1_dat_o = own1 ? (to_hit ? TO_DATA : s_dat_i) : '0;
    wb_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
        .clk(wb_clk_i),
        .rst(wb_rst_i),
        .active(active),
        .ack(s_ack_i),
        .to_hit(to_hit)
    );
    // last = 1 means m1 was served most recently, so m0 wins the first tie after reset
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            st <= IDLE;
            last <= 1'b1;
            timeout_o <= 1'b0;
        end else begin
            case (st)
                IDLE: if (req0 && (!req1 || last)) st <= OWN0;
                      else if (req1) st <= OWN1;
                OWN0: if (!m0_cyc_i) begin
                          st <= IDLE;
                          last <= 1'b0;
                      end
                OWN1: if (!m1_cyc_i) begin
                          st <= IDLE;
                          last <= 1'b1;
                      end
                default: st <= IDLE;
            endcase
            timeout_o <= to_hit | (timeout_o & ~timeout_clr_i);
        end
    end
endmodule
